// File: rtl/vreg_file_sb_if.sv
// Issue/writeback bus of the vector register file: read request, write port,
// destination reservation and the scoreboard vector that comes back.
interface vreg_file_sb_if #(
    parameter int VLEN  = 128,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic                rd_en;
    logic [AW-1:0]       vs1;
    logic [AW-1:0]       vs2;
    logic                rd_stall;
    logic                rvalid;
    logic [VLEN-1:0]     rdata1;
    logic [VLEN-1:0]     rdata2;
    logic                wen;
    logic [AW-1:0]       vd;
    logic [VLEN-1:0]     wdata;
    logic [VLEN/8-1:0]   wmask;
    logic                rsv_en;
    logic [AW-1:0]       rsv_vd;
    logic [NREGS-1:0]    busy;

    modport master (
        output rd_en, vs1, vs2, wen, vd, wdata, wmask, rsv_en, rsv_vd,
        input  rd_stall, rvalid, rdata1, rdata2, busy
    );

    modport slave (
        input  rd_en, vs1, vs2, wen, vd, wdata, wmask, rsv_en, rsv_vd,
        output rd_stall, rvalid, rdata1, rdata2, busy
    );
endinterface

// File: rtl/vreg_file_sb.sv
// Vector register file (v0 hardwired to zero) with byte-masked write, two
// registered bypassing read ports and a reserve/release scoreboard.
module vreg_file_sb #(
    parameter int VLEN  = 128,
    parameter int NREGS = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    vreg_file_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int NB = VLEN / 8;

    logic [VLEN-1:0]  vregs_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic             rvalid_r;
    logic [VLEN-1:0]  rdata1_r;
    logic [VLEN-1:0]  rdata2_r;

    logic             wr_hit_s;
    logic [NREGS-1:0] ebusy_s;
    logic [NREGS-1:0] busy_nxt_s;
    logic             rd_stall_s;
    logic             accept_s;
    logic [VLEN-1:0]  merged_s;
    logic [VLEN-1:0]  rd1_s;
    logic [VLEN-1:0]  rd2_s;

    function automatic logic [VLEN-1:0] merge_bytes(
        input logic [VLEN-1:0] old_v,
        input logic [VLEN-1:0] new_v,
        input logic [NB-1:0]   mask
    );
        logic [VLEN-1:0] res;
        for (int b = 0; b < NB; b++) begin
            res[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    // Hazard detection, post-write value and bypassed read selection
    always_comb begin
        wr_hit_s = bus.wen && (bus.vd != {AW{1'b0}});
        merged_s = merge_bytes(vregs_r[bus.vd], bus.wdata, bus.wmask);
        ebusy_s  = busy_r;
        // A write landing this cycle releases its destination for readers.
        if (bus.wen) begin
            ebusy_s[bus.vd] = 1'b0;
        end else begin
            ebusy_s = busy_r;
        end
        rd_stall_s = bus.rd_en && (ebusy_s[bus.vs1] || ebusy_s[bus.vs2]);
        accept_s   = bus.rd_en && !rd_stall_s;

        if (bus.vs1 == {AW{1'b0}}) begin
            rd1_s = {VLEN{1'b0}};
        end else if (wr_hit_s && (bus.vd == bus.vs1)) begin
            rd1_s = merged_s;
        end else begin
            rd1_s = vregs_r[bus.vs1];
        end

        if (bus.vs2 == {AW{1'b0}}) begin
            rd2_s = {VLEN{1'b0}};
        end else if (wr_hit_s && (bus.vd == bus.vs2)) begin
            rd2_s = merged_s;
        end else begin
            rd2_s = vregs_r[bus.vs2];
        end
    end

    // Scoreboard next state: reserve beats a same-cycle release
    always_comb begin
        busy_nxt_s = {NREGS{1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            if (bus.rsv_en && (bus.rsv_vd == AW'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (bus.wen && (bus.vd == AW'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Register array, scoreboard and read-port pipeline stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                vregs_r[i] <= {VLEN{1'b0}};
            end
            busy_r   <= {NREGS{1'b0}};
            rvalid_r <= 1'b0;
            rdata1_r <= {VLEN{1'b0}};
            rdata2_r <= {VLEN{1'b0}};
        end else begin
            if (wr_hit_s) begin
                vregs_r[bus.vd] <= merged_s;
            end
            busy_r   <= busy_nxt_s;
            rvalid_r <= accept_s;
            if (accept_s) begin
                rdata1_r <= rd1_s;
                rdata2_r <= rd2_s;
            end
        end
    end

    assign bus.rd_stall = rd_stall_s;
    assign bus.rvalid   = rvalid_r;
    assign bus.rdata1   = rdata1_r;
    assign bus.rdata2   = rdata2_r;
    assign bus.busy     = busy_r;
endmodule

// File: doc/vreg_file_sb.md
Name: vreg_file_sb

Overview:
- Parametrised next-generation vector register file: NREGS registers of VLEN bits, v0 hardwired to zero.
- Two registered read ports with write-to-read bypass.
- One write port with a per-byte write mask.
- Integrated scoreboard: destinations are reserved at issue and released on writeback; reads of pending registers stall.
- Sits between the vector decode/issue stage and the vector ALU writeback.

Parameters:
- VLEN, 128: register width in bits; multiple of 8, at least 64.
- NREGS, 32: number of vector registers; power of two, at least 2.
- AW, $clog2(NREGS): register index width (derived, do not override).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- rd_en  in  1  read request for vs1/vs2 this cycle
- vs1  in  AW  source register 1 index
- vs2  in  AW  source register 2 index
- rd_stall  out  1  combinational; read request not accepted this cycle
- rvalid  out  1  registered; rdata1/rdata2 hold data of an accepted read
- rdata1  out  VLEN  registered read data port 1
- rdata2  out  VLEN  registered read data port 2
- wen  in  1  write enable
- vd  in  AW  write destination index
- wdata  in  VLEN  write data
- wmask  in  VLEN/8  byte enables; bit b covers wdata[8b+7:8b]
- rsv_en  in  1  reserve (mark busy) destination rsv_vd
- rsv_vd  in  AW  index to reserve
- busy  out  NREGS  registered scoreboard vector; bit 0 always 0

Behaviour:
- Reset (rst_n=0 at clk edge):
  - all registers cleared to 0, busy=0, rvalid=0, rdata1=rdata2=0.
  - Overrides any wen/rsv_en/rd_en in the same cycle.
  - Aborts a stalled or in-flight read; no rvalid follows.
- v0:
  - reads return 0.
  - writes to v0 are ignored; reserves of v0 are ignored; busy[0] is never set.
- Write (wen=1, vd!=0):
  - on the clock edge, byte b of vregs[vd] is replaced by wdata byte b only where wmask[b]=1; other bytes keep their value.
  - wmask=0 changes no data but still releases busy[vd].
  - Write data is architecturally visible the next cycle.
- Effective busy of register i this cycle: ebusy[i] = busy[i] AND NOT (wen AND vd==i). A concurrent write counts as release.
- rd_stall = rd_en AND (ebusy[vs1] OR ebusy[vs2]). Purely combinational, no dependence on rsv_en.
- Read accepted when rd_en=1 and rd_stall=0. Next cycle: rvalid=1 and rdata1/rdata2 = register contents.
- Bypass: if wen=1 and vd==vsX!=0 in the accept cycle, rdataX takes wdata bytes where wmask=1 and old register bytes elsewhere. Data equals the post-write value.
- vs1==vs2 is legal; both ports return identical data.
- Not accepted (rd_en=0 or stalled): rvalid=0 next cycle; rdata1/rdata2 hold their previous values.
- Read latency is exactly 1 cycle; one read per cycle, fully pipelined.
- Scoreboard update per edge, for each i!=0:
  - busy[i] <= 1 if rsv_en and rsv_vd==i;
  - else busy[i] <= 0 if wen and vd==i;
  - else busy[i] holds.
  - Reserve and write to the same index in one cycle: register data is written AND busy ends set (reserve wins).
- Reserve takes effect from the next cycle. A read in the reserve cycle is evaluated against prior busy state.
- Re-reserving an already busy register keeps it busy; a single write releases it (no counting).
- Writing a non-busy register is legal and leaves busy clear.

Test Plan:
- Reset then read v1,v2 (rd_en=1) → rd_stall=0; next cycle rvalid=1, rdata1=rdata2=0, busy=0.
- Write v3=0x0123456789ABCDEF_FEDCBA9876543210, wmask=all 1; next cycle write v3 wdata=all 0xFF, wmask=16'h000F → read v3 returns 0x0123456789ABCDEF_FEDCBA98FFFFFFFF.
- Write v0=all 1 with rsv_en=1, rsv_vd=0 → read v0 returns 0; busy[0]=0.
- rsv v5; next cycle rd_en vs1=5 → rd_stall=1, rvalid=0 after. Then wen vd=5 wdata=0xAA..AA with rd_en vs1=5 the same cycle → rd_stall=0; next cycle rdata1=0xAA..AA, rvalid=1, busy[5]=0.
- Same cycle rsv_en rsv_vd=7 and wen vd=7 data=0x11..11 → busy[7]=1 next cycle; read v7 stalls; later write vd=7 → busy[7]=0, read returns latest data.
- rsv v4, write v9, then assert rst_n=0 with rd_en=1 vs1=4 stalled → all regs 0, busy=0, rvalid=0; after release, read v4/v9 returns 0 without stall.
